tsc_deserializer: RTL and testbench
===================================

# tsc_deserializer

Downstream receiver for the trigger-surround cache. It samples the cache's serial output `sd` after a trigger (`trd`), reassembles start-bit-framed bytes, and buffers them in a FIFO with a valid/ready output. On `cd` it checks the frame length and reports done or error. Its parallel bytes feed the capture/host-readout logic.

## Interface
- `DATA_W`, 8: bits per sample after each start bit.
- `FIFO_DEPTH`, 16: output FIFO entries; power of two, ≥2.
- `EXPECT_BYTES`, 32: number of samples a complete cache dump must contain.

- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `sd` input 1: serial data from the cache; idle low.
- `trd` input 1: trigger detected; a rising edge arms a new frame.
- `cd` input 1: transfer complete; one-cycle pulse ends the frame.
- `trigtm` input 32: trigger time from the cache; used only with the timestamp feature.
- `out_data` output DATA_W: FIFO head byte.
- `out_valid` output 1: FIFO not empty.
- `out_ready` input 1: consumer accepts the byte when `out_valid` and `out_ready` are both high.
- `byte_count` output $clog2(EXPECT_BYTES)+1: bytes received in the current frame.
- `frame_done` output 1: one-cycle pulse on a good frame end.
- `frame_err` output 1: one-cycle pulse on a bad frame end.
- `overflow` output 1: sticky; a byte was dropped because the FIFO was full.
- `trig_time` output 32: latched trigger time; present only with `TSCRX_TIMESTAMP_EN`.

## Operation
- Line format: idle `sd`=0. Each sample is a start bit `1` followed by DATA_W data bits, MSB first, one bit per clock. There is no stop bit; a following start bit may come immediately.
- State machine:
  - IDLE: ignore `sd` and `cd`. A rising edge of `trd` (detected against the registered previous `trd`) moves to ARMED, clears `byte_count`, and clears `overflow`.
  - ARMED: `sd`=1 moves to SHIFT with the bit counter at 0. `cd`=1 moves to IDLE and pulses done or error per the length check.
  - SHIFT: shift `sd` into the shift register each cycle. On the DATA_W-th bit, push the assembled byte (including the bit sampled on that edge), increment `byte_count` (saturating), and return to ARMED. `cd`=1 in SHIFT discards the partial byte, pulses `frame_err`, and moves to IDLE.
- Length check at `cd` from ARMED: `byte_count`==EXPECT_BYTES gives `frame_done`; any other count gives `frame_err`.
- A `trd` rising edge in ARMED or SHIFT restarts the frame: partial byte discarded, `byte_count` cleared, state ARMED. No error pulse is generated, and the FIFO contents are kept.
- FIFO:
  - A push is accepted when not full, or when full and a pop occurs on the same edge.
  - Otherwise the byte is dropped, `overflow` is set, and `byte_count` still increments.
  - A pop while empty is ignored.
  - Simultaneous push and pop on an empty FIFO is a push only.
  - Pointers are $clog2(FIFO_DEPTH)+1 bits wide; full/empty are decided by the MSB difference and wrap naturally.
- `cd` and `trd` rising on the same cycle: the `cd` action (length check) applies first, and the next state is ARMED with a cleared count.

## Timing
- Reset values: state IDLE, `out_valid`=0, `out_data`=0, `byte_count`=0, `frame_done`=0, `frame_err`=0, `overflow`=0, `trig_time`=0, FIFO empty.
- A start bit sampled at edge S means data bits are sampled at S+1 through S+DATA_W.
- The byte is pushed at edge S+DATA_W, and `out_valid` is high after that edge (latency 0 from the last bit). `out_data` is driven from registered FIFO storage.
- `frame_done` and `frame_err` are high for exactly the one cycle after the edge that samples `cd`.
- `trd` rising-edge detection costs no extra latency: `trd` high at edge T with registered `trd`=0 means the state is ARMED after T, and `sd` is sampled from T+1.
- An asserted reset mid-frame clears immediately, regardless of `clk`.

## Configuration
- `TSCRX_TIMESTAMP_EN` defined:
  - `trig_time` port exists.
  - `trigtm` is latched into `trig_time` on every accepted `trd` rising edge (IDLE, ARMED or SHIFT).
  - `trig_time` holds until the next such edge or reset.
- Not defined:
  - `trig_time` port and register are absent.
  - `trigtm` is unused.
  - All other behaviour is identical.

## Test plan
- Reset, pulse `trd`, send 32 framed bytes 0x00–0x1F back-to-back with `out_ready`=1, then `cd` → 32 bytes out in order, `byte_count`=32, `frame_done` one cycle, `frame_err`=0.
- Same stimulus but only 31 bytes before `cd` → `frame_err` one cycle, `frame_done`=0.
- `cd` asserted 4 bits into the 5th byte → partial byte absent from the FIFO, `byte_count`=4, `frame_err` pulses, state IDLE.
- `out_ready`=0 while sending 20 bytes, FIFO_DEPTH=16 → first 16 bytes retained, `overflow`=1. Then `out_ready`=1 → exactly 16 bytes drain, then `out_valid`=0.
- `trd` pulsed with `trigtm`=0xDEADBEEF (macro defined) → `trig_time`=0xDEADBEEF. A second `trd` with 0x00000010 → 0x00000010. Without the macro, the bench compiles without the `trig_time` port.
- Assert `reset` mid-SHIFT → all outputs at reset values asynchronously. Following `sd` activity is ignored until the next `trd` edge.

Source files
------------

// File: rtl/tsc_deserializer.sv
// Serial receiver for trigger-surround cache dumps: start-bit framed bytes into a valid/ready FIFO.
// Optional trigger timestamp latch enabled by TSCRX_TIMESTAMP_EN.
module tsc_deserializer #(
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int EXPECT_BYTES = 32,
  localparam int CNT_W = $clog2(EXPECT_BYTES) + 1,
  localparam int AW    = $clog2(FIFO_DEPTH),
  localparam int BW    = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sd,
  input  logic              trd,
  input  logic              cd,
  input  logic [31:0]       trigtm,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  byte_count,
  output logic              frame_done,
  output logic              frame_err,
  output logic              overflow
`ifdef TSCRX_TIMESTAMP_EN
  ,
  output logic [31:0]       trig_time
`endif
);

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;

  state_t              state_q, state_d;
  logic                trd_q;
  logic [BW-1:0]       bit_q, bit_d;
  logic [DATA_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [AW:0]         wr_q, wr_d, rd_q, rd_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   mem_d [FIFO_DEPTH];

  logic                trd_rise, len_ok, push, pop, full, empty, push_ok;
  logic [DATA_W-1:0]   assembled;

  assign trd_rise  = trd & ~trd_q;
  assign len_ok    = (cnt_q == CNT_W'(EXPECT_BYTES));
  assign assembled = {sr_q[DATA_W-2:0], sd};

  // Pointers carry one extra wrap bit: equal slots with differing MSB means full.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop     = out_ready & ~empty;
  assign push_ok = push & (~full | pop);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (trd_rise) begin
          state_d = ARMED;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ARMED: begin
        if (cd) begin
          done_d  = len_ok;
          err_d   = ~len_ok;
          state_d = IDLE;
        end
        if (trd_rise) begin
          state_d = ARMED;
          cnt_d   = '0;
        end else if (!cd && sd) begin
          state_d = SHIFT;
          bit_d   = '0;
        end
      end
      SHIFT: begin
        if (cd) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
        if (trd_rise) begin
          state_d = ARMED;
          cnt_d   = '0;
        end else if (!cd) begin
          sr_d = assembled;
          if (bit_q == BW'(DATA_W - 1)) begin
            push    = 1'b1;
            state_d = ARMED;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (push && !push_ok) ovf_d = 1'b1;
  end

  always_comb begin
    wr_d  = wr_q + (AW+1)'(push_ok);
    rd_d  = rd_q + (AW+1)'(pop);
    mem_d = mem_q;
    if (push_ok) mem_d[wr_q[AW-1:0]] = assembled;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      trd_q   <= 1'b0;
      bit_q   <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      trd_q   <= trd;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      mem_q   <= mem_d;
    end
  end

  assign out_data   = mem_q[rd_q[AW-1:0]];
  assign out_valid  = ~empty;
  assign byte_count = cnt_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign overflow   = ovf_q;

`ifdef TSCRX_TIMESTAMP_EN
  logic [31:0] trig_q, trig_d;

  always_comb begin
    trig_d = trig_q;
    if (trd_rise) trig_d = trigtm;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) trig_q <= '0;
    else       trig_q <= trig_d;
  end

  assign trig_time = trig_q;
`else
  logic unused_trigtm;
  assign unused_trigtm = ^trigtm;
`endif

endmodule

// File: tb/tb_tsc_deserializer.sv
// Randomized self-checking bench for tsc_deserializer; expected byte stream and frame verdicts
// come from a queue-based model of the framing rules.
module tb_tsc_deserializer;

  logic        clk = 1'b0;
  logic        reset, sd, trd, cd, out_ready;
  logic [31:0] trigtm;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [5:0]  byte_count;
  logic        frame_done, frame_err, overflow;
`ifdef TSCRX_TIMESTAMP_EN
  logic [31:0] trig_time;
`endif

  int   chk_cnt = 0;
  int   pass_cnt = 0;
  bit   rnd_ready = 1'b0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  tsc_deserializer dut (
    .clk(clk), .reset(reset), .sd(sd), .trd(trd), .cd(cd), .trigtm(trigtm),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .byte_count(byte_count), .frame_done(frame_done), .frame_err(frame_err),
    .overflow(overflow)
`ifdef TSCRX_TIMESTAMP_EN
    , .trig_time(trig_time)
`endif
  );

  always #5 clk = ~clk;

  // Consumer side: a byte is taken on the edge following a negedge where valid&ready.
  always @(negedge clk)
    if (!reset && out_valid && out_ready) got.push_back(out_data);

  task automatic tick();
    @(posedge clk); #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_byte(input logic [7:0] b);
    sd = 1'b1; tick();
    for (int i = 7; i >= 0; i--) begin sd = b[i]; tick(); end
    sd = 1'b0;
  endtask

  task automatic pulse_trd(input logic [31:0] tm);
    sd = 1'b0; trigtm = tm; trd = 1'b1; tick(); trd = 1'b0;
  endtask

  task automatic drain();
    int guard;
    rnd_ready = 1'b0; out_ready = 1'b1; guard = 0;
    while (out_valid && guard < 40) begin tick(); guard++; end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; sd = 0; trd = 0; cd = 0; out_ready = 0; trigtm = 0;
    #3;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_data !== 8'h00) $display("FAIL reset_data got %h want 00", out_data); else pass_cnt++;
    chk_cnt++; if (byte_count !== 6'd0) $display("FAIL reset_count got %0d want 0", byte_count); else pass_cnt++;
    chk_cnt++; if ({frame_done, frame_err, overflow} !== 3'b000)
      $display("FAIL reset_flags got %b want 000", {frame_done, frame_err, overflow}); else pass_cnt++;
`ifdef TSCRX_TIMESTAMP_EN
    chk_cnt++; if (trig_time !== 32'h0) $display("FAIL reset_trig_time got %h want 0", trig_time); else pass_cnt++;
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();
  endtask

  task automatic run_frame(input int n, input bit short_cd_name);
    got.delete(); out_ready = 1'b1;
    pulse_trd(32'h0);
    for (int i = 0; i < n; i++) send_byte(8'(i));
    chk_cnt++; if (byte_count !== 6'(n)) $display("FAIL frame%0d_count got %0d want %0d", n, byte_count, n); else pass_cnt++;
    cd = 1'b1; tick(); cd = 1'b0;
    chk_cnt++; if (frame_done !== (n == 32)) $display("FAIL frame%0d_done got %b want %b", n, frame_done, n == 32); else pass_cnt++;
    chk_cnt++; if (frame_err !== (n != 32)) $display("FAIL frame%0d_err got %b want %b", n, frame_err, n != 32); else pass_cnt++;
    tick();
    chk_cnt++; if ({frame_done, frame_err} !== 2'b00) $display("FAIL frame%0d_pulse_width got %b want 00", n, {frame_done, frame_err}); else pass_cnt++;
    drain();
    chk_cnt++; if (got.size() !== n) $display("FAIL frame%0d_nbytes got %0d want %0d", n, got.size(), n); else pass_cnt++;
    for (int i = 0; i < n; i++) begin
      chk_cnt++;
      if (i >= got.size() || got[i] !== 8'(i))
        $display("FAIL frame%0d_byte%0d got %h want %h", n, i, (i < got.size()) ? got[i] : 8'hxx, 8'(i));
      else pass_cnt++;
    end
    if (short_cd_name) ;
  endtask

  task automatic test_full_frame();  run_frame(32, 1'b0); endtask
  task automatic test_short_frame(); run_frame(31, 1'b1); endtask

  task automatic test_cd_partial();
    got.delete(); out_ready = 1'b1;
    pulse_trd(32'h0);
    for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i));
    sd = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin sd = 1'b1; tick(); end
    sd = 1'b1; cd = 1'b1; tick(); cd = 1'b0; sd = 1'b0;
    chk_cnt++; if (frame_err !== 1'b1) $display("FAIL partial_err got %b want 1", frame_err); else pass_cnt++;
    chk_cnt++; if (byte_count !== 6'd4) $display("FAIL partial_count got %0d want 4", byte_count); else pass_cnt++;
    send_byte(8'hFF); // must be ignored in IDLE
    drain();
    chk_cnt++; if (got.size() !== 4) $display("FAIL partial_nbytes got %0d want 4", got.size()); else pass_cnt++;
    chk_cnt++; if (byte_count !== 6'd4) $display("FAIL idle_ignores_sd got %0d want 4", byte_count); else pass_cnt++;
  endtask

  task automatic test_overflow();
    got.delete(); exp_q.delete(); out_ready = 1'b0;
    pulse_trd(32'h0);
    for (int i = 0; i < 20; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      exp_q.push_back(b);
      send_byte(b);
    end
    chk_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow); else pass_cnt++;
    chk_cnt++; if (byte_count !== 6'd20) $display("FAIL ovf_count got %0d want 20", byte_count); else pass_cnt++;
    drain();
    chk_cnt++; if (got.size() !== 16) $display("FAIL ovf_nbytes got %0d want 16", got.size()); else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      chk_cnt++;
      if (i >= got.size() || got[i] !== exp_q[i])
        $display("FAIL ovf_byte%0d got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
      else pass_cnt++;
    end
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL ovf_empty got %b want 0", out_valid); else pass_cnt++;
    cd = 1'b1; tick(); cd = 1'b0;
    chk_cnt++; if (frame_err !== 1'b1) $display("FAIL ovf_frame_err got %b want 1", frame_err); else pass_cnt++;
    pulse_trd(32'h0);
    chk_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", overflow); else pass_cnt++;
    cd = 1'b1; tick(); cd = 1'b0; tick();
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 8; f++) begin
      int n, j, k;
      bit restart;
      got.delete(); exp_q.delete();
      n = (f % 3 == 2) ? 32 : int'($urandom_range(1, 12));
      restart = 1'($urandom_range(0, 1));
      rnd_ready = (n != 32); out_ready = 1'b1;
      pulse_trd(32'h0);
      if (restart) begin
        j = $urandom_range(0, 3);
        k = $urandom_range(0, 7);
        for (int i = 0; i < j; i++) begin
          logic [7:0] b;
          b = 8'($urandom); exp_q.push_back(b); send_byte(b);
        end
        sd = 1'b1; tick();
        for (int i = 0; i < k; i++) begin sd = 1'($urandom); tick(); end
        pulse_trd(32'h0);
      end
      for (int i = 0; i < n; i++) begin
        logic [7:0] b;
        b = 8'($urandom); exp_q.push_back(b); send_byte(b);
        repeat ($urandom_range(0, 2)) tick();
      end
      chk_cnt++; if (byte_count !== 6'(n)) $display("FAIL rnd%0d_count got %0d want %0d", f, byte_count, n); else pass_cnt++;
      cd = 1'b1; tick(); cd = 1'b0;
      chk_cnt++; if ({frame_done, frame_err} !== {n == 32, n != 32})
        $display("FAIL rnd%0d_verdict got %b want %b", f, {frame_done, frame_err}, {n == 32, n != 32}); else pass_cnt++;
      drain();
      chk_cnt++; if (got.size() !== exp_q.size()) $display("FAIL rnd%0d_nbytes got %0d want %0d", f, got.size(), exp_q.size()); else pass_cnt++;
      for (int i = 0; i < exp_q.size(); i++) begin
        chk_cnt++;
        if (i >= got.size() || got[i] !== exp_q[i])
          $display("FAIL rnd%0d_byte%0d got %h want %h", f, i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_cd_trd_same();
    got.delete(); out_ready = 1'b1;
    pulse_trd(32'h0);
    for (int i = 0; i < 32; i++) send_byte(8'(i));
    cd = 1'b1; trd = 1'b1; tick(); cd = 1'b0; trd = 1'b0;
    chk_cnt++; if (frame_done !== 1'b1) $display("FAIL same_done got %b want 1", frame_done); else pass_cnt++;
    chk_cnt++; if (byte_count !== 6'd0) $display("FAIL same_count got %0d want 0", byte_count); else pass_cnt++;
    send_byte(8'h5A);
    chk_cnt++; if (byte_count !== 6'd1) $display("FAIL same_rearmed got %0d want 1", byte_count); else pass_cnt++;
    cd = 1'b1; tick(); cd = 1'b0;
    chk_cnt++; if (frame_err !== 1'b1) $display("FAIL same_next_err got %b want 1", frame_err); else pass_cnt++;
    drain();
  endtask

`ifdef TSCRX_TIMESTAMP_EN
  task automatic test_timestamp();
    pulse_trd(32'hDEADBEEF);
    chk_cnt++; if (trig_time !== 32'hDEADBEEF) $display("FAIL ts_first got %h want deadbeef", trig_time); else pass_cnt++;
    trigtm = 32'h12345678; tick();
    chk_cnt++; if (trig_time !== 32'hDEADBEEF) $display("FAIL ts_hold got %h want deadbeef", trig_time); else pass_cnt++;
    pulse_trd(32'h00000010);
    chk_cnt++; if (trig_time !== 32'h00000010) $display("FAIL ts_second got %h want 00000010", trig_time); else pass_cnt++;
    cd = 1'b1; tick(); cd = 1'b0; tick();
  endtask
`endif

  task automatic test_reset_mid();
    out_ready = 1'b0;
    pulse_trd(32'hCAFE0001);
    send_byte(8'h11); send_byte(8'h22);
    sd = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin sd = 1'b1; tick(); end
    #2 reset = 1'b1;
    #1;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_data !== 8'h00) $display("FAIL rmid_data got %h want 00", out_data); else pass_cnt++;
    chk_cnt++; if (byte_count !== 6'd0) $display("FAIL rmid_count got %0d want 0", byte_count); else pass_cnt++;
`ifdef TSCRX_TIMESTAMP_EN
    chk_cnt++; if (trig_time !== 32'h0) $display("FAIL rmid_trig_time got %h want 0", trig_time); else pass_cnt++;
`endif
    @(negedge clk); reset = 1'b0;
    tick();
    send_byte(8'hFF); send_byte(8'h81);
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rmid_ignore_valid got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (byte_count !== 6'd0) $display("FAIL rmid_ignore_count got %0d want 0", byte_count); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_cd_partial();
    test_overflow();
    test_random_frames();
    test_cd_trd_same();
`ifdef TSCRX_TIMESTAMP_EN
    test_timestamp();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
